// File: rtl/konane_cursor_ctrl.sv
// konane_cursor_ctrl
// ------------------
// Human-player front end for the 6x6 Konane engine. Button pulses move a
// board cursor; select / give-up presses are checked locally against the
// latched selectable mask and give-up permission. Only legal picks are sent
// to the engine on the op handshake. The engine's result (re handshake)
// refreshes the mask, the player to move and the give-up permission.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. While valid is high, its payload is held stable. Valid never
// waits on ready. op_valid is high only in S_ISSUE, and re_ready is high only
// in S_WAIT_RE, so every accepted op is followed by exactly one accepted
// result before the next op.
//
// Configuration macro: KONANE_CURSOR_SNAP_EN. When it is defined, the cursor
// jumps to the lowest set bit of the newly latched mask on every result.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   btn_up/down/left/right     single-cycle cursor move pulses
//   btn_sel, btn_giveup        pick the cursor cell / give up
//   op_valid, op_ready         op handshake; payload op_i, op_j (signed, -1 = give up)
//   re_valid, re_ready         result handshake; payload re_is_finished,
//                              re_next_player_id, re_player_can_giveup, re_selectable
//   cur_i, cur_j               cursor row/column 0..5
//   sel_mask                   latched selectable mask, bit index 6*i+j
//   cur_player                 player to move (0 = black)
//   can_giveup                 latched give-up permission
//   game_over, winner          last game finished / its winner
//   err                        one-cycle pulse after a rejected press
//   busy                       high whenever not in S_PICK
module konane_cursor_ctrl #(
    parameter logic [35:0] INIT_MASK = 36'h004001004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic        btn_giveup,
    input  logic        op_ready,
    output logic        op_valid,
    output logic [4:0]  op_i,
    output logic [4:0]  op_j,
    input  logic        re_valid,
    output logic        re_ready,
    input  logic        re_is_finished,
    input  logic        re_next_player_id,
    input  logic        re_player_can_giveup,
    input  logic [35:0] re_selectable,
    output logic [2:0]  cur_i,
    output logic [2:0]  cur_j,
    output logic [35:0] sel_mask,
    output logic        cur_player,
    output logic        can_giveup,
    output logic        game_over,
    output logic        winner,
    output logic        err,
    output logic        busy
);

    localparam logic [1:0] S_PICK    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT_RE = 2'd2;

    logic [1:0]  state;
    logic        mover;       // player whose op is in flight
    logic [5:0]  cell_idx;
    logic        one_dir;
    logic [35:0] new_mask;

    // Handshake flags decode straight from state so they clear together
    // with the asynchronous reset.
    assign op_valid = (state == S_ISSUE);
    assign re_ready = (state == S_WAIT_RE);
    assign busy     = (state != S_PICK);

    assign cell_idx = ({3'b000, cur_i} * 6'd6) + {3'b000, cur_j};
    assign one_dir  = $onehot({btn_up, btn_down, btn_left, btn_right});

    // A finished game restarts from the opening mask; the engine's mask is
    // irrelevant then.
    assign new_mask = re_is_finished ? INIT_MASK : re_selectable;

`ifdef KONANE_CURSOR_SNAP_EN
    logic [5:0] snap_idx;
    logic [2:0] snap_i;
    logic [2:0] snap_j;

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        snap_idx = 6'd0;
        for (int k = 35; k >= 0; k--) begin
            if (new_mask[k]) snap_idx = 6'(k);
        end
    end
    assign snap_i = 3'(snap_idx / 6'd6);
    assign snap_j = 3'(snap_idx % 6'd6);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_PICK;
            op_i       <= 5'd0;
            op_j       <= 5'd0;
            cur_i      <= 3'd0;
            cur_j      <= 3'd0;
            sel_mask   <= INIT_MASK;
            cur_player <= 1'b0;
            can_giveup <= 1'b0;
            game_over  <= 1'b0;
            winner     <= 1'b0;
            mover      <= 1'b0;
            err        <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                S_PICK: begin
                    // Give-up beats select; a direction pulse alongside
                    // either is dropped.
                    if (btn_giveup) begin
                        if (can_giveup) begin
                            op_i  <= 5'b11111;
                            op_j  <= 5'b11111;
                            state <= S_ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (btn_sel) begin
                        if (sel_mask[cell_idx]) begin
                            op_i  <= {2'b00, cur_i};
                            op_j  <= {2'b00, cur_j};
                            state <= S_ISSUE;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (one_dir) begin
                        if (btn_up)    cur_i <= (cur_i == 3'd0) ? 3'd5 : cur_i - 3'd1;
                        if (btn_down)  cur_i <= (cur_i == 3'd5) ? 3'd0 : cur_i + 3'd1;
                        if (btn_left)  cur_j <= (cur_j == 3'd0) ? 3'd5 : cur_j - 3'd1;
                        if (btn_right) cur_j <= (cur_j == 3'd5) ? 3'd0 : cur_j + 3'd1;
                    end
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        game_over <= 1'b0;
                        mover     <= cur_player;
                        state     <= S_WAIT_RE;
                    end
                end
                S_WAIT_RE: begin
                    if (re_valid) begin
                        sel_mask <= new_mask;
                        if (re_is_finished) begin
                            game_over  <= 1'b1;
                            winner     <= mover;
                            cur_player <= 1'b0;
                            can_giveup <= 1'b0;
                        end else begin
                            cur_player <= re_next_player_id;
                            can_giveup <= re_player_can_giveup;
                        end
`ifdef KONANE_CURSOR_SNAP_EN
                        if (|new_mask) begin
                            cur_i <= snap_i;
                            cur_j <= snap_j;
                        end
`endif
                        state <= S_PICK;
                    end
                end
                default: state <= S_PICK;
            endcase
        end
    end

endmodule

// File: tb/tb_konane_cursor_ctrl.sv
// Testbench for konane_cursor_ctrl: directed scenarios followed by random
// buttons and random engine behaviour, every cycle checked against a
// behavioural model of the cursor controller kept in this file.
module tb_konane_cursor_ctrl;

    localparam logic [35:0] INIT = 36'h004001004;
    // button vector order: {giveup, sel, right, left, down, up}
    localparam logic [5:0] B_UP = 6'b000001, B_DOWN = 6'b000010, B_LEFT = 6'b000100,
                           B_RIGHT = 6'b001000, B_SEL = 6'b010000, B_GIVEUP = 6'b100000;
    localparam int PICK = 0, ISSUE = 1, WAIT = 2;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_up, btn_down, btn_left, btn_right, btn_sel, btn_giveup;
    logic op_ready, op_valid, re_valid, re_ready;
    logic [4:0] op_i, op_j;
    logic re_is_finished, re_next_player_id, re_player_can_giveup;
    logic [35:0] re_selectable, sel_mask;
    logic [2:0] cur_i, cur_j;
    logic cur_player, can_giveup, game_over, winner, err, busy;

    always #5 clk = ~clk;

    konane_cursor_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_sel(btn_sel), .btn_giveup(btn_giveup),
        .op_ready(op_ready), .op_valid(op_valid), .op_i(op_i), .op_j(op_j),
        .re_valid(re_valid), .re_ready(re_ready), .re_is_finished(re_is_finished),
        .re_next_player_id(re_next_player_id), .re_player_can_giveup(re_player_can_giveup),
        .re_selectable(re_selectable), .cur_i(cur_i), .cur_j(cur_j), .sel_mask(sel_mask),
        .cur_player(cur_player), .can_giveup(can_giveup), .game_over(game_over),
        .winner(winner), .err(err), .busy(busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // behavioural model
    int          m_phase, m_i, m_j;
    logic [35:0] m_mask;
    logic        m_cg, m_pl, m_go, m_win, m_err, m_mover;
    logic [4:0]  m_opi, m_opj;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PICK; m_i = 0; m_j = 0; m_mask = INIT;
        m_cg = 0; m_pl = 0; m_go = 0; m_win = 0; m_err = 0; m_mover = 0;
        m_opi = 0; m_opj = 0;
    endtask

    task automatic check_model();
        chk("op_valid",   {35'd0, op_valid},   {35'd0, m_phase == ISSUE});
        chk("re_ready",   {35'd0, re_ready},   {35'd0, m_phase == WAIT});
        chk("busy",       {35'd0, busy},       {35'd0, m_phase != PICK});
        chk("op_i",       {31'd0, op_i},       {31'd0, m_opi});
        chk("op_j",       {31'd0, op_j},       {31'd0, m_opj});
        chk("cur_i",      {33'd0, cur_i},      36'(m_i));
        chk("cur_j",      {33'd0, cur_j},      36'(m_j));
        chk("sel_mask",   sel_mask,            m_mask);
        chk("cur_player", {35'd0, cur_player}, {35'd0, m_pl});
        chk("can_giveup", {35'd0, can_giveup}, {35'd0, m_cg});
        chk("game_over",  {35'd0, game_over},  {35'd0, m_go});
        chk("winner",     {35'd0, winner},     {35'd0, m_win});
        chk("err",        {35'd0, err},        {35'd0, m_err});
    endtask

    // One clock of stimulus: inputs applied now, model advanced by the rules
    // of the game front end, outputs compared just after the edge.
    task automatic cycle(input logic [5:0] b, input logic ordy, input logic rv,
                         input logic fin, input logic nxt, input logic pcg,
                         input logic [35:0] rsel);
        int ndir;
        {btn_giveup, btn_sel, btn_right, btn_left, btn_down, btn_up} = b;
        op_ready = ordy; re_valid = rv; re_is_finished = fin;
        re_next_player_id = nxt; re_player_can_giveup = pcg; re_selectable = rsel;
        m_err = 0;
        ndir = int'(b[0]) + int'(b[1]) + int'(b[2]) + int'(b[3]);
        if (m_phase == PICK) begin
            if (b[5]) begin
                if (m_cg) begin m_opi = 5'h1f; m_opj = 5'h1f; m_phase = ISSUE; end
                else m_err = 1;
            end else if (b[4]) begin
                if (m_mask[6*m_i + m_j]) begin
                    m_opi = 5'(m_i); m_opj = 5'(m_j); m_phase = ISSUE;
                end else m_err = 1;
            end else if (ndir == 1) begin
                if (b[0]) m_i = (m_i + 5) % 6;
                if (b[1]) m_i = (m_i + 1) % 6;
                if (b[2]) m_j = (m_j + 5) % 6;
                if (b[3]) m_j = (m_j + 1) % 6;
            end
        end else if (m_phase == ISSUE) begin
            if (ordy) begin m_go = 0; m_mover = m_pl; m_phase = WAIT; end
        end else begin
            if (rv) begin
                if (fin) begin
                    m_go = 1; m_win = m_mover; m_mask = INIT; m_pl = 0; m_cg = 0;
                end else begin
                    m_mask = rsel; m_pl = nxt; m_cg = pcg;
                end
`ifdef KONANE_CURSOR_SNAP_EN
                for (int k = 35; k >= 0; k--)
                    if (m_mask[k]) begin m_i = k / 6; m_j = k % 6; end
`endif
                m_phase = PICK;
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic press(input logic [5:0] b);
        cycle(b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0);
    endtask

    initial begin
        logic [5:0]  rb;
        logic [35:0] rm;
        int          r;
        rst_n = 1'b0;
        {btn_giveup, btn_sel, btn_right, btn_left, btn_down, btn_up} = 6'd0;
        op_ready = 0; re_valid = 0; re_is_finished = 0;
        re_next_player_id = 0; re_player_can_giveup = 0; re_selectable = 36'd0;
        model_reset();
        #12;
        check_model();
        chk("reset_mask", sel_mask, INIT);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // cursor wrap and simultaneous directions
        press(B_UP);          chk("up_wrap_i", {33'd0, cur_i}, 36'd5);
        press(B_LEFT);        chk("left_wrap_j", {33'd0, cur_j}, 36'd5);
        press(B_UP | B_LEFT); chk("two_dir_i", {33'd0, cur_i}, 36'd5);
        chk("two_dir_err", {35'd0, err}, 36'd0);
        press(B_DOWN);
        press(B_RIGHT);       chk("right_wrap_j", {33'd0, cur_j}, 36'd0);

        // illegal then legal select
        press(B_SEL);         chk("bad_sel_err", {35'd0, err}, 36'd1);
        chk("bad_sel_opv", {35'd0, op_valid}, 36'd0);
        press(B_RIGHT);       chk("err_one_cycle", {35'd0, err}, 36'd0);
        press(B_RIGHT);
        press(B_SEL);         chk("sel_opv", {35'd0, op_valid}, 36'd1);
        chk("sel_opi", {31'd0, op_i}, 36'd0);
        chk("sel_opj", {31'd0, op_j}, 36'd2);

        // engine stalls; stray re_valid must not be accepted
        repeat (5) begin
            cycle(6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'hfff);
            chk("stall_opj", {31'd0, op_j}, 36'd2);
        end
        cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0);
        chk("hs_opv_low", {35'd0, op_valid}, 36'd0);
        chk("hs_re_ready", {35'd0, re_ready}, 36'd1);

        // first result
        cycle(6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 36'h000004002);
        chk("res_mask", sel_mask, 36'h000004002);
        chk("res_cg", {35'd0, can_giveup}, 36'd1);
        chk("res_pl", {35'd0, cur_player}, 36'd1);
`ifdef KONANE_CURSOR_SNAP_EN
        chk("snap_j", {33'd0, cur_j}, 36'd1);
`else
        chk("keep_j", {33'd0, cur_j}, 36'd2);
`endif

        // give-up beats select
        press(B_GIVEUP | B_SEL);
        chk("gu_opi", {31'd0, op_i}, 36'h1f);
        chk("gu_opj", {31'd0, op_j}, 36'h1f);
        cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0);
        cycle(6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 36'hfffffffff);
        press(B_GIVEUP | B_SEL);
        chk("gu_denied_err", {35'd0, err}, 36'd1);
        chk("gu_denied_busy", {35'd0, busy}, 36'd0);

        // black moves and the game ends
        press(B_SEL);
        cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0);
        cycle(6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 36'h123);
        chk("fin_go", {35'd0, game_over}, 36'd1);
        chk("fin_win", {35'd0, winner}, 36'd0);
        chk("fin_mask", sel_mask, INIT);
        chk("fin_pl", {35'd0, cur_player}, 36'd0);
        press(B_SEL);
        chk("go_held", {35'd0, game_over}, 36'd1);
        cycle(6'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 36'd0);
        chk("go_cleared", {35'd0, game_over}, 36'd0);

        // asynchronous reset in the middle of an op
        cycle(6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 36'hfffffffff);
        press(B_DOWN);
        press(B_SEL);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_model();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // random play
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1, 2, 3: rb = 6'd1 << r;
                4:          rb = 6'(($urandom_range(1, 15) | 6'h3) & 6'hf);
                5, 6, 7:    rb = B_SEL | (($urandom_range(0, 3) == 0) ? B_LEFT : 6'd0);
                8:          rb = B_GIVEUP;
                9:          rb = B_GIVEUP | B_SEL;
                default:    rb = 6'd0;
            endcase
            rm = {4'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) rm[6*m_i + m_j] = 1'b1;
            cycle(rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom), rm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/konane_cursor_ctrl.md
# konane_cursor_ctrl

Human-player front end for the 6x6 Konane game engine. Turns single-cycle button pulses into a board cursor and issues moves on the engine's operation handshake (`op_*`). It consumes the engine's result handshake (`re_*`) and latches the selectable mask for the next pick. Moves to non-selectable cells are rejected locally, so the engine only ever receives legal cell picks or a legal give-up.

## Interface
Parameters:
- `INIT_MASK`, default `36'h004001004`: selectable mask before the first move (black movable pieces at bits 2, 12, 26). Bit index is 6*i+j.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn_up`, `btn_down`, `btn_left`, `btn_right`  in  1 each  debounced single-cycle pulses.
- `btn_sel`  in  1  select pulse.
- `btn_giveup`  in  1  give-up pulse.
- `op_ready`  in  1  engine accepts an op.
- `op_valid`  out  1  op request.
- `op_i`, `op_j`  out  5 (signed) each  row/column; -1 (5'b11111) means give up.
- `re_valid`  in  1  engine result valid.
- `re_ready`  out  1  result accept.
- `re_is_finished`, `re_next_player_id`, `re_player_can_giveup`  in  1 each  result fields.
- `re_selectable`  in  36  result mask.
- `cur_i`, `cur_j`  out  3 each  cursor position, 0..5.
- `sel_mask`  out  36  latched selectable mask.
- `cur_player`  out  1  player to move (0 = black).
- `can_giveup`  out  1  latched give-up permission.
- `game_over`  out  1  last game finished.
- `winner`  out  1  winner of the last game.
- `err`  out  1  one-cycle pulse on a rejected press.
- `busy`  out  1  high whenever the state is not S_PICK.

## Operation
- States and transitions:
  - S_PICK: buttons honoured.
  - S_ISSUE: `op_valid`=1.
  - S_WAIT_RE: `re_ready`=1.
  - S_PICK -> S_ISSUE on accepted select or give-up.
  - S_ISSUE -> S_WAIT_RE on `op_valid & op_ready`.
  - S_WAIT_RE -> S_PICK on `re_valid & re_ready`.
- Cursor: up = i-1, down = i+1, left = j-1, right = j+1, all mod 6 (0-1 -> 5, 5+1 -> 0).
- Two or more direction pulses in the same cycle: no movement, no `err`.
- All buttons are ignored outside S_PICK.
- `btn_giveup` has priority over `btn_sel`. A direction pulse in the same cycle as either is ignored.
- Select:
  - If `sel_mask[6*cur_i+cur_j]`=1, load `op_i`=cur_i and `op_j`=cur_j (zero-extended).
  - Otherwise pulse `err`; state unchanged.
- Give-up:
  - If `can_giveup`=1, load `op_i`=`op_j`=-1.
  - Otherwise pulse `err`.
- On op acceptance in S_ISSUE: clear `game_over`, and store `mover`=`cur_player`.
- On result acceptance with `re_is_finished`=0:
  - `sel_mask` <= `re_selectable`
  - `can_giveup` <= `re_player_can_giveup`
  - `cur_player` <= `re_next_player_id`
- On result acceptance with `re_is_finished`=1:
  - `game_over` <= 1, `winner` <= `mover`
  - `sel_mask` <= `INIT_MASK`, `cur_player` <= 0, `can_giveup` <= 0
  - The engine's `re_selectable` is ignored.
- Every accepted op yields exactly one result. No second op is issued before it arrives.

## Timing
- Reset values:
  - `op_valid`=0, `op_i`=`op_j`=0, `re_ready`=0
  - `cur_i`=`cur_j`=0, `sel_mask`=`INIT_MASK`
  - `cur_player`=0, `can_giveup`=0, `game_over`=0, `winner`=0, `err`=0, `busy`=0
  - state S_PICK
- Cursor updates the cycle after the pulse is sampled.
- `err` is high for exactly the cycle after the offending pulse.
- `op_valid` rises the cycle after an accepted press.
- While waiting for `op_ready`, `op_valid` and `op_i`/`op_j` are held stable. `op_valid` falls the cycle after the handshake.
- `re_ready` rises the cycle after the op handshake and falls the cycle after the result handshake.
- The new `sel_mask` is usable in S_PICK the cycle after the result handshake.
- If `re_valid` arrives while the state is not S_WAIT_RE: not accepted (`re_ready`=0).
- Asynchronous reset mid-transaction: every output returns to its reset value immediately. The engine is reset by the same `rst_n`.

## Configuration
- `KONANE_CURSOR_SNAP_EN` defined: on every result acceptance, the cursor moves to the lowest-index set bit k of the newly latched mask (cur_i=k/6, cur_j=k%6). If the mask is zero, the cursor is unchanged.
- Not defined: the cursor keeps its position across results.
- Reset cursor is (0,0) in both builds.

## Test plan
- Reset, `btn_up` once -> cursor (5,0); then `btn_left` -> (5,5); up+left in the same cycle -> no move, `err`=0.
- Cursor (0,0), `btn_sel` with `INIT_MASK` -> `err` pulse, `op_valid` stays 0; move to (0,2), `btn_sel` -> `op_valid`=1, `op_i`=0, `op_j`=2.
- Engine holds `op_ready`=0 for 5 cycles -> `op_valid`, `op_i`, `op_j` stable; `op_ready`=1 -> `op_valid`=0 next cycle, `re_ready`=1.
- Result with `re_selectable`=36'h000004002, `re_player_can_giveup`=1, `re_next_player_id`=1 -> `sel_mask` latched, `can_giveup`=1, `cur_player`=1. With SNAP_EN the cursor goes to (0,1); without, it is unchanged.
- `btn_giveup`+`btn_sel` in the same cycle with `can_giveup`=1 -> `op_i`=`op_j`=5'b11111. With `can_giveup`=0 -> `err` only.
- Result with `re_is_finished`=1 after black's move -> `game_over`=1, `winner`=0, `sel_mask`=36'h004001004, `cur_player`=0; the next accepted op clears `game_over`.
